// File: rtl/ofdm_pkg.sv
// Shared 802.11a receive constants: modulation encoding and the
// per-modulation symbol geometry used by the deinterleaver.
package ofdm_pkg;

  localparam int MAX_CBPS = 288;
  localparam int CBPS_W   = 9;

  typedef enum logic [1:0] {
    MOD_BPSK  = 2'd0,
    MOD_QPSK  = 2'd1,
    MOD_QAM16 = 2'd2,
    MOD_QAM64 = 2'd3
  } mod_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_e;

  // Coded bits per OFDM symbol
  function automatic logic [CBPS_W-1:0] cbps_of(input logic [1:0] m);
    case (m)
      MOD_BPSK:  return 9'd48;
      MOD_QPSK:  return 9'd96;
      MOD_QAM16: return 9'd192;
      default:   return 9'd288;
    endcase
  endfunction

  // s = max(N_BPSC/2, 1)
  function automatic logic [1:0] s_of(input logic [1:0] m);
    case (m)
      MOD_BPSK:  return 2'd1;
      MOD_QPSK:  return 2'd1;
      MOD_QAM16: return 2'd2;
      default:   return 2'd3;
    endcase
  endfunction

  // N_CBPS / 16
  function automatic logic [4:0] d16_of(input logic [1:0] m);
    case (m)
      MOD_BPSK:  return 5'd3;
      MOD_QPSK:  return 5'd6;
      MOD_QAM16: return 5'd12;
      default:   return 5'd18;
    endcase
  endfunction

endpackage

// File: rtl/rx_deintlvr_addr_gen.sv
// Incremental deinterleaver write-address generator: produces the original
// coded-bit index k for the current received index j without dividers.
module rx_deintlvr_addr_gen
  import ofdm_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_advance,
  input  logic [1:0]        i_s,
  input  logic [4:0]        i_d16,
  output logic [CBPS_W-1:0] o_k
);

  // j is split as b + jm with b = s*floor(j/s). Because N/16 is a multiple
  // of s, floor(16j/N) == floor(b/(N/16)) == r_brow, and k collapses to
  // 16*(b mod N/16 + r) + r_brow with r = (jm + r_brow) mod s.
  logic [1:0] r_jm;
  logic [1:0] r_qm;
  logic [4:0] r_bcol;
  logic [3:0] r_brow;

  logic [2:0] w_sum;
  logic [1:0] w_r;
  logic [4:0] w_col;
  logic [5:0] w_bcol_step;

  always_comb begin
    w_sum       = {1'b0, r_jm} + {1'b0, r_qm};
    w_r         = (w_sum >= {1'b0, i_s}) ? 2'(w_sum - {1'b0, i_s}) : w_sum[1:0];
    w_col       = r_bcol + {3'b000, w_r};
    w_bcol_step = {1'b0, r_bcol} + {4'b0000, i_s};
    o_k         = {w_col, 4'b0000} + {5'b00000, r_brow};
  end

  always_ff @(posedge clk) begin
    if (!reset || i_start) begin
      r_jm   <= '0;
      r_qm   <= '0;
      r_bcol <= '0;
      r_brow <= '0;
    end else if (i_advance) begin
      if (r_jm == i_s - 2'd1) begin
        r_jm <= '0;
        if (w_bcol_step >= {1'b0, i_d16}) begin
          r_bcol <= '0;
          r_brow <= r_brow + 4'd1;
          r_qm   <= (r_qm == i_s - 2'd1) ? 2'd0 : r_qm + 2'd1;
        end else begin
          r_bcol <= w_bcol_step[4:0];
        end
      end else begin
        r_jm <= r_jm + 2'd1;
      end
    end
  end

endmodule

// File: rtl/rx_deinterleaver.sv
// 802.11a receive deinterleaver: writes each symbol into a ping-pong bank at
// its original coded index, then streams the bank out in order k = 0..N-1.
//   state   | meaning
//   RD_IDLE | no full bank pending, outputs idle
//   RD_READ | streaming bank r_rbank, one address per cycle
module rx_deinterleaver
  import ofdm_pkg::*;
#(
  parameter int SOFT_W   = 3,
  parameter int MAX_CBPS = ofdm_pkg::MAX_CBPS
)(
  input  logic              clk_Modulation,
  input  logic              reset,
  input  logic [1:0]        rx_Modulation,
  input  logic              deintlvr_in_valid,
  input  logic [SOFT_W-1:0] deintlvr_in_bit,
  output logic              deintlvr_out_valid,
  output logic [SOFT_W-1:0] deintlvr_out_bit,
  output logic              deintlvr_sym_last,
  output logic              deintlvr_err
);

  localparam int AW = $clog2(2 * MAX_CBPS);

  logic              r_vld_d;
  logic [1:0]        r_mod;
  logic [CBPS_W-1:0] r_wcnt;
  logic              r_wbank;
  logic              r_err;

  logic              r_s1_valid;
  logic [SOFT_W-1:0] r_s1_bit;
  logic [CBPS_W-1:0] r_s1_k;
  logic              r_s1_bank;
  logic              r_s1_last;
  logic [1:0]        r_s1_mod;

  logic [1:0]        r_full;
  logic [1:0]        r_bmod [2];
  logic [SOFT_W-1:0] r_mem [2*MAX_CBPS];
  logic [SOFT_W-1:0] r_rd_data;

  rd_state_e         r_state;
  rd_state_e         w_state_nxt;
  logic [CBPS_W-1:0] r_rk;
  logic [CBPS_W-1:0] w_rk_nxt;
  logic              r_rbank;
  logic              w_rbank_nxt;
  logic              r_out_valid;
  logic              r_sym_last;
  logic              w_rd_en;
  logic              w_rd_done;
  logic              w_rd_lastk;
  logic [CBPS_W-1:0] w_rn;

  logic              w_rise;
  logic [1:0]        w_mod;
  logic [CBPS_W-1:0] w_n;
  logic              w_last;
  logic              w_ag_start;
  logic              w_ag_adv;
  logic [CBPS_W-1:0] w_k;
  logic [AW-1:0]     w_waddr;
  logic [AW-1:0]     w_raddr;

  // The modulation of the first bit of a frame comes straight from the port;
  // after that the latched copy is used so mid-frame changes are ignored.
  always_comb begin
    w_rise     = deintlvr_in_valid & ~r_vld_d;
    w_mod      = w_rise ? rx_Modulation : r_mod;
    w_n        = cbps_of(w_mod);
    w_last     = deintlvr_in_valid & (r_wcnt == w_n - 9'd1);
    w_ag_start = ~deintlvr_in_valid | w_last;
    w_ag_adv   = deintlvr_in_valid & ~w_last;
  end

  rx_deintlvr_addr_gen u_addr_gen (
    .clk       (clk_Modulation),
    .reset     (reset),
    .i_start   (w_ag_start),
    .i_advance (w_ag_adv),
    .i_s       (s_of(w_mod)),
    .i_d16     (d16_of(w_mod)),
    .o_k       (w_k)
  );

  always_ff @(posedge clk_Modulation) begin
    if (!reset) begin
      r_vld_d    <= 1'b0;
      r_mod      <= '0;
      r_wcnt     <= '0;
      r_wbank    <= 1'b0;
      r_err      <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s1_bit   <= '0;
      r_s1_k     <= '0;
      r_s1_bank  <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_mod   <= '0;
    end else begin
      r_vld_d <= deintlvr_in_valid;
      if (w_rise) r_mod <= rx_Modulation;
      // A frame that stops mid-symbol leaves r_wbank untouched, so the
      // partial data is simply overwritten by the next frame.
      r_err <= ~deintlvr_in_valid & (r_wcnt != '0);
      if (!deintlvr_in_valid) begin
        r_wcnt <= '0;
      end else if (w_last) begin
        r_wcnt  <= '0;
        r_wbank <= ~r_wbank;
      end else begin
        r_wcnt <= r_wcnt + 9'd1;
      end
      r_s1_valid <= deintlvr_in_valid;
      r_s1_bit   <= deintlvr_in_bit;
      r_s1_k     <= w_k;
      r_s1_bank  <= r_wbank;
      r_s1_last  <= w_last;
      r_s1_mod   <= w_mod;
    end
  end

  always_ff @(posedge clk_Modulation) begin
    if (!reset) begin
      r_full    <= '0;
      r_bmod[0] <= '0;
      r_bmod[1] <= '0;
    end else begin
      if (w_rd_done) r_full[r_rbank] <= 1'b0;
      if (r_s1_valid && r_s1_last) begin
        r_full[r_s1_bank] <= 1'b1;
        r_bmod[r_s1_bank] <= r_s1_mod;
      end
    end
  end

  always_comb begin
    w_waddr = r_s1_bank ? AW'(r_s1_k) + AW'(MAX_CBPS) : AW'(r_s1_k);
    w_raddr = r_rbank   ? AW'(r_rk)   + AW'(MAX_CBPS) : AW'(r_rk);
  end

  always_ff @(posedge clk_Modulation) begin
    if (r_s1_valid) r_mem[w_waddr] <= r_s1_bit;
    if (w_rd_en) r_rd_data <= r_mem[w_raddr];
  end

  // Each bank carries its own length so a modulation change between frames
  // does not affect symbols already queued.
  always_comb begin
    w_state_nxt = r_state;
    w_rk_nxt    = r_rk;
    w_rbank_nxt = r_rbank;
    w_rd_en     = 1'b0;
    w_rd_done   = 1'b0;
    w_rd_lastk  = 1'b0;
    w_rn        = cbps_of(r_bmod[r_rbank]);
    case (r_state)
      RD_IDLE: begin
        w_rk_nxt = '0;
        if (r_full[r_rbank]) w_state_nxt = RD_READ;
      end
      RD_READ: begin
        w_rd_en = 1'b1;
        if (r_rk == w_rn - 9'd1) begin
          w_rd_done   = 1'b1;
          w_rd_lastk  = 1'b1;
          w_rk_nxt    = '0;
          w_rbank_nxt = ~r_rbank;
          if (!r_full[~r_rbank]) w_state_nxt = RD_IDLE;
        end else begin
          w_rk_nxt = r_rk + 9'd1;
        end
      end
      default: w_state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk_Modulation) begin
    if (!reset) begin
      r_state     <= RD_IDLE;
      r_rk        <= '0;
      r_rbank     <= 1'b0;
      r_out_valid <= 1'b0;
      r_sym_last  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rk        <= w_rk_nxt;
      r_rbank     <= w_rbank_nxt;
      r_out_valid <= w_rd_en;
      r_sym_last  <= w_rd_lastk;
    end
  end

  assign deintlvr_out_valid = r_out_valid;
  assign deintlvr_out_bit   = r_out_valid ? r_rd_data : '0;
  assign deintlvr_sym_last  = r_sym_last;
  assign deintlvr_err       = r_err;

endmodule

// File: tb/tb_rx_deinterleaver.sv
// Scoreboard bench for rx_deinterleaver: symbols are built in original order,
// interleaved by a transmit-side model, and the output stream is compared.
module tb_rx_deinterleaver;

  logic       clk_Modulation = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] rx_Modulation = 2'd0;
  logic       deintlvr_in_valid = 1'b0;
  logic [2:0] deintlvr_in_bit = 3'd0;
  logic       deintlvr_out_valid;
  logic [2:0] deintlvr_out_bit;
  logic       deintlvr_sym_last;
  logic       deintlvr_err;

  always #5 clk_Modulation = ~clk_Modulation;

  rx_deinterleaver #(.SOFT_W(3), .MAX_CBPS(288)) dut (
    .clk_Modulation     (clk_Modulation),
    .reset              (reset),
    .rx_Modulation      (rx_Modulation),
    .deintlvr_in_valid  (deintlvr_in_valid),
    .deintlvr_in_bit    (deintlvr_in_bit),
    .deintlvr_out_valid (deintlvr_out_valid),
    .deintlvr_out_bit   (deintlvr_out_bit),
    .deintlvr_sym_last  (deintlvr_sym_last),
    .deintlvr_err       (deintlvr_err)
  );

  typedef struct packed {
    logic [2:0] b;
    logic       last;
  } exp_t;

  exp_t       exp_q[$];
  logic [2:0] stim_q[$];
  exp_t       mon_e;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_last = 0;
  int first_rise = -1;
  int run_len = 0;
  int last_run = 0;
  int err_cnt = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk_Modulation) cyc <= cyc + 1;

  always @(negedge clk_Modulation) begin
    if (deintlvr_err === 1'b1) err_cnt++;
    if (deintlvr_out_valid === 1'b1) begin
      if (prev_valid !== 1'b1) first_rise = cyc;
      run_len++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got bit %0d last %0b, required no output", deintlvr_out_bit, deintlvr_sym_last);
      end else begin
        mon_e = exp_q.pop_front();
        if (deintlvr_out_bit !== mon_e.b || deintlvr_sym_last !== mon_e.last) begin
          errors++;
          $display("FAIL out_bit: got bit %0d last %0b, required bit %0d last %0b",
                   deintlvr_out_bit, deintlvr_sym_last, mon_e.b, mon_e.last);
        end
      end
    end else if (prev_valid === 1'b1) begin
      last_run = run_len;
      run_len  = 0;
    end
    prev_valid = deintlvr_out_valid;
  end

  function automatic int bpsc_of(input logic [1:0] m);
    case (m)
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 6;
    endcase
  endfunction

  // Builds one symbol: original sequence c[k] goes to the scoreboard, the
  // transmit-interleaved sequence goes to the stimulus queue.
  task automatic add_symbol(input logic [1:0] m, input bit onehot, input int oh_j, input int oh_k);
    int n, s, i, j;
    logic [2:0] c [288];
    logic [2:0] tx [288];
    exp_t e;
    n = 48 * bpsc_of(m);
    s = (bpsc_of(m) / 2 > 1) ? bpsc_of(m) / 2 : 1;
    for (int k = 0; k < n; k++) begin
      if (onehot) c[k] = (k == oh_k) ? 3'd7 : 3'd0;
      else        c[k] = 3'($urandom_range(0, 7));
    end
    if (onehot) begin
      for (int jj = 0; jj < n; jj++) tx[jj] = (jj == oh_j) ? 3'd7 : 3'd0;
    end else begin
      for (int k = 0; k < n; k++) begin
        i = (n / 16) * (k % 16) + k / 16;
        j = s * (i / s) + (i + n - (16 * i) / n) % s;
        tx[j] = c[k];
      end
    end
    for (int jj = 0; jj < n; jj++) stim_q.push_back(tx[jj]);
    for (int k = 0; k < n; k++) begin
      e.b = c[k];
      e.last = (k == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic add_raw(input int nbits);
    for (int q = 0; q < nbits; q++) stim_q.push_back(3'($urandom_range(0, 7)));
  endtask

  task automatic drive_frame(input logic [1:0] m, input bit close);
    bit first = 1'b1;
    while (stim_q.size() > 0) begin
      @(negedge clk_Modulation);
      deintlvr_in_valid = 1'b1;
      rx_Modulation     = first ? m : 2'($urandom_range(0, 3));
      first             = 1'b0;
      deintlvr_in_bit   = stim_q.pop_front();
      if (stim_q.size() == 0) t_last = cyc + 1;
    end
    if (close) begin
      @(negedge clk_Modulation);
      deintlvr_in_valid = 1'b0;
      deintlvr_in_bit   = 3'd0;
    end
  endtask

  task automatic wait_drain(input string tag);
    int t = 0;
    while ((exp_q.size() != 0 || deintlvr_out_valid === 1'b1) && t < 3000) begin
      @(negedge clk_Modulation);
      t++;
    end
    repeat (5) @(negedge clk_Modulation);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s: %0d outputs outstanding, required 0", tag, exp_q.size());
    end
  endtask

  task automatic check_int(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", tag, got, want);
    end
  endtask

  initial begin
    logic [1:0] m;
    int nsym;

    repeat (3) @(negedge clk_Modulation);
    check_int("reset_outputs", {deintlvr_out_valid, deintlvr_out_bit, deintlvr_sym_last, deintlvr_err}, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk_Modulation);

    add_symbol(2'd0, 1'b1, 1, 16);
    drive_frame(2'd0, 1'b1);
    wait_drain("bpsk_onehot");
    check_int("bpsk_latency", first_rise, t_last + 3);
    check_int("bpsk_run_len", last_run, 48);

    add_symbol(2'd1, 1'b1, 6, 1);
    drive_frame(2'd1, 1'b1);
    wait_drain("qpsk_onehot");
    check_int("qpsk_latency", first_rise, t_last + 3);

    add_symbol(2'd3, 1'b1, 18, 17);
    drive_frame(2'd3, 1'b1);
    wait_drain("qam64_j18");
    add_symbol(2'd3, 1'b1, 1, 16);
    drive_frame(2'd3, 1'b1);
    wait_drain("qam64_j1");
    check_int("qam64_run_len", last_run, 288);

    for (int q = 0; q < 3; q++) add_symbol(2'd2, 1'b0, 0, 0);
    drive_frame(2'd2, 1'b1);
    wait_drain("qam16_stream");
    check_int("qam16_run_len", last_run, 576);
    check_int("no_err_on_boundary", err_cnt, 0);

    add_raw(100);
    drive_frame(2'd3, 1'b1);
    repeat (10) @(negedge clk_Modulation);
    check_int("err_pulses", err_cnt, 1);
    add_symbol(2'd0, 1'b0, 0, 0);
    drive_frame(2'd0, 1'b1);
    wait_drain("bpsk_after_err");
    check_int("err_pulses_after", err_cnt, 1);

    add_symbol(2'd3, 1'b0, 0, 0);
    add_raw(150);
    drive_frame(2'd3, 1'b0);
    @(negedge clk_Modulation);
    check_int("reading_before_reset", int'(deintlvr_out_valid), 1);
    reset = 1'b0;
    @(posedge clk_Modulation);
    #1 exp_q.delete();
    @(negedge clk_Modulation);
    check_int("outputs_after_reset", {deintlvr_out_valid, deintlvr_out_bit, deintlvr_sym_last, deintlvr_err}, 0);
    deintlvr_in_valid = 1'b0;
    @(negedge clk_Modulation);
    reset = 1'b1;
    repeat (400) @(negedge clk_Modulation);
    add_symbol(2'd0, 1'b0, 0, 0);
    drive_frame(2'd0, 1'b1);
    wait_drain("bpsk_after_reset");
    check_int("bpsk_after_reset_len", last_run, 48);

    add_symbol(2'd0, 1'b0, 0, 0);
    drive_frame(2'd0, 1'b1);
    add_symbol(2'd3, 1'b0, 0, 0);
    drive_frame(2'd3, 1'b1);
    wait_drain("back_to_back");

    for (int it = 0; it < 4; it++) begin
      m = 2'($urandom_range(0, 3));
      nsym = $urandom_range(1, 2);
      for (int q = 0; q < nsym; q++) add_symbol(m, 1'b0, 0, 0);
      drive_frame(m, 1'b1);
      wait_drain("random");
      check_int("random_run_len", last_run, nsym * 48 * bpsc_of(m));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not reach its end within the time limit");
    $fatal(1);
  end

endmodule

// File: doc/rx_deinterleaver.md
Name: rx_deinterleaver

Overview:
- Receive-side 802.11a data-field deinterleaver; the inverse of the transmit interleaver.
- Sits between the demapper (soft-bit output) and depuncture/Viterbi.
- Collects one OFDM symbol (N_CBPS soft bits) in received order and replays it in original coded order.
- Ping-pong bit memory gives continuous symbol streaming with no backpressure.

Parameters:
- SOFT_W, 3, soft-bit width per coded bit.
- MAX_CBPS, 288, bank depth (64-QAM N_CBPS).

Ports:
- clk_Modulation  in  1  single clock.
- reset  in  1  synchronous, active-low (reset==0 resets).
- rx_Modulation  in  2  0=BPSK(48), 1=QPSK(96), 2=16-QAM(192), 3=64-QAM(288).
- deintlvr_in_valid  in  1  high for every input bit of a frame; contiguous over the frame.
- deintlvr_in_bit  in  SOFT_W  soft bit, received order j.
- deintlvr_out_valid  out  1  output bit valid.
- deintlvr_out_bit  out  SOFT_W  soft bit, deinterleaved order k.
- deintlvr_sym_last  out  1  qualifies the final bit (k=N-1) of each symbol.
- deintlvr_err  out  1  one-cycle pulse when a frame ends mid-symbol.

Behaviour:
- Reset (reset==0 at an edge):
  - All outputs 0.
  - Write/read counters 0; both banks empty; write bank = 0.
  - Reset mid-symbol abandons all stored data; no output follows.
- Modulation latch:
  - rx_Modulation is captured on the first cycle of in_valid (rising edge).
  - It is held for the whole frame; changes mid-frame are ignored.
- Constants per modulation:
  - N = 48/96/192/288.
  - s = max(N_BPSC/2, 1) = 1/1/2/3.
  - N/16 = 3/6/12/18.
- Write address (for each accepted bit j = 0..N-1):
  - i = s*floor(j/s) + (j + floor(16j/N)) mod s.
  - k = 16i - (N-1)*floor(16i/N).
  - The bit is written to the write bank at address k.
  - No dividers or multipliers: floor(16j/N) is a counter stepping every N/16 inputs; the other terms are incremental counters.
- Pipeline:
  - Stage 1 registers the input and computes k.
  - Stage 2 performs the RAM write.
  - After j = N-1 is written, the bank is marked full, the bank index swaps, and j returns to 0.
- Read FSM (states IDLE, READ):
  - IDLE -> READ when a full bank is pending.
  - In READ, addresses k = 0..N-1 are read, one per cycle.
  - READ -> IDLE after k = N-1, unless the other bank is already full; then READ continues directly on that bank with no gap.
  - RAM read latency is 1 cycle.
  - out_valid asserts for exactly N consecutive cycles per symbol.
  - sym_last is high with k = N-1.
- Latency: out_valid for k=0 rises exactly 3 cycles after the edge that samples in bit j=N-1.
- Overlap: because input is at most 1 bit/cycle, reading one bank (N cycles) always completes before the other bank fills. No overflow state exists.
- Frame end mid-symbol (in_valid falls with 0 < j < N):
  - Discard the partial bank.
  - Pulse deintlvr_err 1 cycle after the falling edge.
  - Reset j to 0.
  - Any full bank already queued still drains normally.
- Frame end on a symbol boundary: no error.
- Back-to-back frames: a new in_valid rise may occur on the cycle after a fall. The new modulation applies only to the new frame's symbols; symbols already queued keep their own N.
- Per-bank N: each bank stores its N alongside its data so the read length is correct across a modulation change.

Decomposition:
- Package ofdm_pkg: modulation encoding constants; N_CBPS, s, and N/16 lookup functions indexed by modulation; MAX_CBPS.
- Sub-module rx_deintlvr_addr_gen:
  - Inputs: start, advance, modulation constants.
  - Output: k for the current j, with all floor/mod terms held as wrap counters.
  - Unit-testable against the closed-form equations.
- Bank RAM: inferred simple dual-port memory of 2*MAX_CBPS x SOFT_W; no separate module.

Test Plan:
- BPSK, one symbol, one-hot input at j=1 (value 3'b111), all other bits 0 -> out_valid for 48 cycles; nonzero only at k=16; sym_last on the 48th cycle; first out_valid 3 cycles after j=47 is sampled.
- QPSK, one-hot at j=6 -> nonzero output only at k=1.
- 64-QAM, one-hot at j=18 -> nonzero only at k=17; one-hot at j=1 -> only at k=16.
- 16-QAM, 3 contiguous symbols of random bits through a behavioural 802.11a interleaver model -> output equals the original sequence; 576 continuous out_valid cycles with no gaps; sym_last every 192nd.
- 64-QAM frame of 100 bits -> deintlvr_err pulses once; no out_valid. The next BPSK frame of 48 bits deinterleaves correctly.
- reset=0 asserted at j=150 of a 64-QAM symbol -> outputs 0 next cycle; no output after release. A fresh BPSK symbol then round-trips correctly.
